regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Write-back queue between the execute/memory stages and the 32x32 `register_file` write port. It accepts destination-register/result pairs over a valid/ready handshake, buffers them in a small FIFO, and retires one entry per cycle onto the register file's `reg_write`/`write_reg`/`write_data` port. It also provides youngest-entry forwarding for two read addresses, so queued-but-unretired results stay visible to the decode stage.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `DATA_WIDTH`, default 32: result width.
- `ADDR_WIDTH`, default 5: register index width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: producer has a result.
- `in_ready` output 1: queue can accept.
- `in_rd` input ADDR_WIDTH: destination register.
- `in_data` input DATA_WIDTH: result value.
- `wb_stall` input 1: hold the head entry; no retire this cycle.
- `reg_write` output 1: to `register_file.reg_write`.
- `write_reg` output ADDR_WIDTH: to `register_file.write_reg`.
- `write_data` output DATA_WIDTH: to `register_file.write_data`.
- `read_reg1`, `read_reg2` input ADDR_WIDTH: decode-stage read addresses.
- `fwd_hit1`, `fwd_hit2` output 1: a matching entry is queued.
- `fwd_data1`, `fwd_data2` output DATA_WIDTH: data of the youngest matching entry.
- `empty` output 1: queue holds no entries.

## Operation
- FIFO state:
  - Write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` is 0..DEPTH.
  - Per-entry `rd`, `data` and a valid bit.
- Accept: `in_valid && in_ready` at a rising edge.
  - If `in_rd != 0`, the entry is stored at `wp`, `wp` increments and `count` increments.
  - If `in_rd == 0`, the handshake completes but nothing is stored.
- `in_ready = (count != DEPTH)`. There is no same-cycle pass-through when full: a retire on the same edge frees space only for the following cycle.
- Retire: `reg_write = !empty && !wb_stall`.
  - `write_reg`/`write_data` carry the head entry when `!empty`, and 0 otherwise.
  - On a rising edge with `reg_write=1`, `rp` increments and `count` decrements.
- Simultaneous accept and retire: `count` is unchanged and both pointers advance.
- Ordering: strictly FIFO. Duplicate destinations are kept, so the register file receives every write in order.
- Forwarding (combinational):
  - `fwd_hitN = 1` iff `read_regN != 0` and some valid entry has `rd == read_regN`.
  - `fwd_dataN` is the data of the youngest such entry (closest to `wp`), and 0 when there is no hit.
  - The head entry being retired this cycle still counts as a hit.
- Reset while operating: all entries are discarded immediately. In-flight results are lost; the pipeline must be flushed alongside this block.

## Timing
- Reset values: `in_ready=1`, `reg_write=0`, `write_reg=0`, `write_data=0`, `fwd_hit1/2=0`, `fwd_data1/2=0`, `empty=1`. Internally `count=0`, `wp=rp=0`, all valid bits 0.
- Latency: a result accepted at edge N drives `reg_write=1` during cycle N..N+1 (if no stall) and is written into the register file at edge N+1.
- `reg_write`, `write_*`, `in_ready`, `empty` and `fwd_*` are combinational from registered state plus `wb_stall`/`read_regN`. There is no combinational path from `in_valid` to `in_ready`.
- Throughput: one accept and one retire per cycle sustained.
- Wrap-around: pointers roll from DEPTH-1 to 0 without a bubble.
- Full with `wb_stall=1`: `in_ready` stays 0 and the producer must hold `in_valid`/`in_rd`/`in_data` stable.

## Configuration
- `REGFILE_WBQ_FWD_EN` defined: forwarding comparators are built as described in Operation.
- Not defined: no comparators are built, and `fwd_hit1/2` and `fwd_data1/2` are tied to 0. Decode must then stall on any pending destination, found by checking `empty`.

## Test plan
- Reset, then accept `(x1, 0x12345678)` with `wb_stall=0` -> next cycle `reg_write=1, write_reg=1, write_data=0x12345678`; then `empty=1`.
- Accept `(x0, 0xDEADBEEF)` -> `in_ready=1` at accept, `reg_write` never asserts, `empty` stays 1.
- `wb_stall=1`, push x1..x4 with values 0x1001..0x1004 -> `in_ready=0` after the 4th accept; release the stall -> four writes in order x1..x4 on consecutive cycles, then `in_ready=1`.
- With the forwarding macro defined, `wb_stall=1`, push `(x5, 0xAAAA)` then `(x5, 0xBBBB)`, `read_reg1=5`, `read_reg2=6` -> `fwd_hit1=1, fwd_data1=0xBBBB, fwd_hit2=0`. Without the macro -> both hits 0.
- Full queue with simultaneous accept attempt and retire -> the accept is refused that cycle and accepted the next; `count` returns to DEPTH. Ten back-to-back accept/retire pairs -> pointers wrap with no lost or reordered writes.
- Assert `reset` mid-burst with 3 entries queued -> `reg_write=0`, `empty=1` and `in_ready=1` immediately (asynchronous), and no stale writes follow deassertion.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back FIFO between execute/memory and the register file write port, with
// youngest-entry forwarding for two read ports (built only when REGFILE_WBQ_FWD_EN is defined).
module regfile_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  wb_stall,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_WIDTH-1:0] fwd_data1,
    output logic [DATA_WIDTH-1:0] fwd_data2,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      vld_q;
    logic [PW-1:0]         wp_q, wp_d;
    logic [PW-1:0]         rp_q, rp_d;
    logic [PW:0]           count_q, count_d;

    logic store;
    logic retire;

    assign empty      = (count_q == '0);
    assign in_ready   = (count_q != FULL_COUNT);
    assign reg_write  = !empty && !wb_stall;
    assign write_reg  = empty ? '0 : rd_q[rp_q];
    assign write_data = empty ? '0 : data_q[rp_q];

    // Writes to x0 complete the handshake but are dropped, never occupying a slot.
    assign store  = in_valid && in_ready && (in_rd != '0);
    assign retire = reg_write;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (store) begin
            wp_d = wp_q + 1'b1;
        end
        if (retire) begin
            rp_d = rp_q + 1'b1;
        end
        case ({store, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            // Store and retire never target the same slot: that would need empty and full at once.
            if (store) begin
                rd_q[wp_q]   <= in_rd;
                data_q[wp_q] <= in_data;
                vld_q[wp_q]  <= 1'b1;
            end
            if (retire) begin
                vld_q[rp_q] <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WBQ_FWD_EN
    logic [PW-1:0] scanIdx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        scanIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = rp_q + PW'(i);
            if (vld_q[scanIdx] && (read_reg1 != '0) && (rd_q[scanIdx] == read_reg1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[scanIdx];
            end
            if (vld_q[scanIdx] && (read_reg2 != '0) && (rd_q[scanIdx] == read_reg2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_q[scanIdx];
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{read_reg1, read_reg2, vld_q};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: the driver pushes expected writes, a negedge
// monitor compares every output against a queue-based model and pops retired entries.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic        empty;

    entry_t sbq[$];
    entry_t pendEntry;
    logic   pendValid = 1'b0;
    int     cmpCount  = 0;
    int     errCount  = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: commit the previous edge's accept, then drive new inputs.
    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                                 input logic st, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        if (pendValid) sbq.push_back(pendEntry);
        in_valid  = v;
        in_rd     = rd;
        in_data   = d;
        wb_stall  = st;
        read_reg1 = r1;
        read_reg2 = r2;
        pendValid = !reset && v && (sbq.size() != DEPTH) && (rd != 5'd0);
        pendEntry.rd   = rd;
        pendEntry.data = d;
    endtask

    task automatic applyIdle(input int n, input logic st);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, st, 5'd0, 5'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic applyReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        sbq.delete();
        pendValid = 1'b0;
        #1;
        checkOutput("async_reset_reg_write", {31'd0, reg_write}, 32'd0);
        checkOutput("async_reset_empty",     {31'd0, empty},     32'd1);
        checkOutput("async_reset_in_ready",  {31'd0, in_ready},  32'd1);
        applyIdle(2, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        logic        expRw;
        logic        expHit1, expHit2;
        logic [31:0] expData1, expData2;
        expRw    = (sbq.size() != 0) && !wb_stall && !reset;
        expHit1  = 1'b0;
        expHit2  = 1'b0;
        expData1 = 32'd0;
        expData2 = 32'd0;
`ifdef REGFILE_WBQ_FWD_EN
        foreach (sbq[i]) begin
            if (read_reg1 != 5'd0 && sbq[i].rd == read_reg1) begin
                expHit1  = 1'b1;
                expData1 = sbq[i].data;
            end
            if (read_reg2 != 5'd0 && sbq[i].rd == read_reg2) begin
                expHit2  = 1'b1;
                expData2 = sbq[i].data;
            end
        end
`endif
        checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, sbq.size() != DEPTH});
        checkOutput("empty",     {31'd0, empty},     {31'd0, sbq.size() == 0});
        checkOutput("reg_write", {31'd0, reg_write}, {31'd0, expRw});
        checkOutput("write_reg",  {27'd0, write_reg}, (sbq.size() != 0) ? {27'd0, sbq[0].rd} : 32'd0);
        checkOutput("write_data", write_data,         (sbq.size() != 0) ? sbq[0].data : 32'd0);
        checkOutput("fwd_hit1",  {31'd0, fwd_hit1},  {31'd0, expHit1});
        checkOutput("fwd_hit2",  {31'd0, fwd_hit2},  {31'd0, expHit2});
        checkOutput("fwd_data1", fwd_data1, expData1);
        checkOutput("fwd_data2", fwd_data2, expData2);
        if (expRw) void'(sbq.pop_front());
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rd     = 5'd0;
        in_data   = 32'd0;
        wb_stall  = 1'b0;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single write to x1");
        applyStimulus(1'b1, 5'd1, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
        applyIdle(3, 1'b0);

        $display("[TB] write to x0 is dropped");
        applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        applyIdle(3, 1'b0);

        $display("[TB] fill under stall, then drain in order");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd9, 32'h9999, 1'b1, 5'd0, 5'd0);
        applyIdle(6, 1'b0);

        $display("[TB] forwarding of duplicate destinations");
        applyStimulus(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 5'd6);
        applyStimulus(1'b1, 5'd5, 32'hBBBB, 1'b1, 5'd5, 5'd6);
        applyStimulus(1'b0, 5'd0, 32'd0,    1'b1, 5'd5, 5'd6);
        applyStimulus(1'b0, 5'd0, 32'd0,    1'b0, 5'd5, 5'd6);
        applyIdle(3, 1'b0);

        $display("[TB] full queue with simultaneous accept attempt and retire");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i + 10), 32'h2000 + 32'(i), 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd7, 32'h7777, 1'b0, 5'd7, 5'd11);
        applyStimulus(1'b1, 5'd7, 32'h7777, 1'b1, 5'd7, 5'd11);
        applyIdle(7, 1'b0);

        $display("[TB] back-to-back accept/retire with wrap-around");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'(i + 1), 32'h3000 + 32'(i), 1'b0, 5'(i), 5'(i + 1));
        applyIdle(3, 1'b0);

        $display("[TB] reset mid-burst");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 5'(i + 20), 32'h4000 + 32'(i), 1'b1, 5'd0, 5'd0);
        applyReset();
        applyIdle(4, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) applyReset();
            applyStimulus(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
                          ($urandom % 3) == 0, 5'($urandom % 8), 5'($urandom % 8));
        end
        applyIdle(DEPTH + 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
